// File: rtl/intc_prio_nest.sv
// rtl/intc_prio_nest.sv - N-line vectored interrupt controller with nested priority preemption
module intc_prio_nest #(
  parameter int N_IRQ = 8,
  parameter int ADDR_W = 16,
  parameter logic [ADDR_W-1:0] VEC_BASE = 'h0010,
  parameter int VEC_STRIDE = 4,
  parameter int NEST_DEPTH = 4,
  localparam int ID_W = $clog2(N_IRQ)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [N_IRQ-1:0]  irq_in,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_sel,
  input  logic [N_IRQ-1:0]  cfg_wdata,
  input  logic              Call,
  input  logic              Ret,
  output logic              INTjmp,
  output logic [ADDR_W-1:0] Addr,
  output logic [ID_W-1:0]   irq_id,
  output logic [N_IRQ-1:0]  pending_o,
  output logic [N_IRQ-1:0]  active_o,
  output logic              nest_full
);

  localparam int DW = $clog2(NEST_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP} state_t;

  state_t           state;
  logic [N_IRQ-1:0] irq_s1, irq_s2, irq_prev;
  logic [N_IRQ-1:0] pend_q, en_q, mode_q, active_q;
  logic [ID_W-1:0]  stk [NEST_DEPTH];
  logic [DW-1:0]    depth;

  logic             stk_empty, stk_full;
  logic [N_IRQ-1:0] top_mask, id_mask, rise, pend_eff, req_vec;
  logic [N_IRQ-1:0] mode_next, pend_next;
  logic [ID_W-1:0]  cand;
  logic             cand_any, eligible;
  logic             do_call, do_push, do_pop;
  logic [ADDR_W-1:0] cand_addr;

  // stk[0] is always the top of the in-service stack
  assign stk_empty = (depth == '0);
  assign stk_full  = (depth == DW'(NEST_DEPTH));
  assign top_mask  = stk_empty ? '0 : (N_IRQ'(1) << stk[0]);
  assign id_mask   = N_IRQ'(1) << irq_id;
  assign rise      = irq_s2 & ~irq_prev;

  // level lines follow the synced input, except the one currently being serviced
  assign pend_eff  = (pend_q & mode_q) | (irq_s2 & ~mode_q & ~top_mask);
  assign req_vec   = pend_eff & en_q;
  assign cand_any  = |req_vec;
  assign eligible  = cand_any && !stk_full && (stk_empty || (cand < stk[0]));
  assign cand_addr = VEC_BASE + ADDR_W'(cand) * ADDR_W'(VEC_STRIDE);

  assign do_call   = (state == S_REQ) && Call;
  assign do_pop    = Ret && !stk_empty;
  assign do_push   = do_call && (!stk_full || do_pop);

  assign pending_o = pend_eff;
  assign active_o  = active_q;
  assign nest_full = stk_full;

  // fixed priority: lowest requesting index wins
  always_comb begin
    cand = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req_vec[i]) cand = ID_W'(i);
    end
  end

  // next latched pending: cfg set/clear, acknowledge clear, then hardware edges win
  always_comb begin
    mode_next = (cfg_we && cfg_sel == 2'd1) ? cfg_wdata : mode_q;
    pend_next = pend_q;
    if (cfg_we && cfg_sel == 2'd2) pend_next = pend_next | cfg_wdata;
    if (cfg_we && cfg_sel == 2'd3) pend_next = pend_next & ~cfg_wdata;
    if (do_call) pend_next = pend_next & ~id_mask;
    pend_next = pend_next | (rise & mode_q);
    pend_next = pend_next & mode_next;
  end

  // two-flop synchroniser plus previous value for edge detection
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      irq_s1   <= '0;
      irq_s2   <= '0;
      irq_prev <= '0;
    end else begin
      irq_s1   <= irq_in;
      irq_s2   <= irq_s1;
      irq_prev <= irq_s2;
    end
  end

  // configuration and latched pending state
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      en_q   <= '0;
      mode_q <= '1;
      pend_q <= '0;
    end else begin
      if (cfg_we && cfg_sel == 2'd0) en_q <= cfg_wdata;
      mode_q <= mode_next;
      pend_q <= pend_next;
    end
  end

  // in-service stack: pop happens before push so Ret+Call keeps the depth
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < NEST_DEPTH; i++) stk[i] <= '0;
      depth    <= '0;
      active_q <= '0;
    end else begin
      if (do_pop && do_push) begin
        stk[0] <= irq_id;
      end else if (do_push) begin
        for (int i = NEST_DEPTH - 1; i > 0; i--) stk[i] <= stk[i-1];
        stk[0] <= irq_id;
        depth  <= depth + DW'(1);
      end else if (do_pop) begin
        for (int i = 0; i < NEST_DEPTH - 1; i++) stk[i] <= stk[i+1];
        stk[NEST_DEPTH-1] <= '0;
        depth <= depth - DW'(1);
      end
      active_q <= (active_q & ~(do_pop ? top_mask : '0)) | (do_push ? id_mask : '0);
    end
  end

  // request FSM with registered vector outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= S_IDLE;
      INTjmp <= 1'b0;
      Addr   <= '0;
      irq_id <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (eligible) begin
            state  <= S_REQ;
            INTjmp <= 1'b1;
            Addr   <= cand_addr;
            irq_id <= cand;
          end
        end
        S_REQ: begin
          if (Call) begin
            state  <= S_GAP;
            INTjmp <= 1'b0;
          end else if (eligible) begin
            Addr   <= cand_addr;
            irq_id <= cand;
          end else begin
            state  <= S_IDLE;
            INTjmp <= 1'b0;
          end
        end
        S_GAP: begin
          state <= S_IDLE;
        end
        default: begin
          state  <= S_IDLE;
          INTjmp <= 1'b0;
        end
      endcase
    end
  end

endmodule
